memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
//  Memory-side end of the packet link driven by memory_controller. Pops request
//  packets from the link receive FIFO, decodes read/write, drives a synchronous
//  word RAM, and pushes a read-response packet (data only) back over the send FIFO.
//  Serves one request at a time, in order.
// PARAMETERS
//  DATA_WIDTH_BYTE  4   data word bytes; DATA_WIDTH = 8*DATA_WIDTH_BYTE
//  ADDR_WIDTH_BYTE  4   request address bytes; ADDR_WIDTH = 8*ADDR_WIDTH_BYTE
//  MEM_ADDR_WIDTH   16  RAM word-address width
//  READ_LATENCY     1   cycles from mem_en (read) to mem_rdata valid, >=1
//  localparam SEND_BYTE = DATA_WIDTH_BYTE+ADDR_WIDTH_BYTE+DATA_WIDTH_BYTE/8+1 (9)
// PORTS
//  CLK          in   1                clock, rising edge
//  RST_N        in   1                asynchronous reset, active low
//  receivable   in   1                receive FIFO holds a packet
//  recv_data    in   SEND_BYTE*8      packet payload, LSB-aligned
//  recv_length  in   5                packet length in bytes
//  recv_flag    out  1                1-cycle pop pulse to receive FIFO
//  sendable     in   1                send FIFO can accept a packet
//  send_flag    out  1                1-cycle push pulse to send FIFO
//  send_data    out  SEND_BYTE*8      response payload
//  send_length  out  5                response length in bytes
//  mem_en       out  1                RAM access strobe
//  mem_we       out  DATA_WIDTH_BYTE  byte write enables (0 = read)
//  mem_addr     out  MEM_ADDR_WIDTH   RAM word address
//  mem_wdata    out  DATA_WIDTH       RAM write data
//  mem_rdata    in   DATA_WIDTH       RAM read data
//  err          out  1                1-cycle pulse: malformed packet dropped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latency counter 0; asynchronous, any state.
//  Decode (IDLE, receivable=1), DW=DATA_WIDTH, AW=ADDR_WIDTH:
//   read : recv_length==ADDR_WIDTH_BYTE+1 and recv_data[AW]==0; addr=[AW-1:0]
//   write: recv_length==SEND_BYTE and recv_data[DW+AW+DATA_WIDTH_BYTE]==1;
//          data=[DW-1:0], addr=[DW+AW-1:DW], mask=[DW+AW+DATA_WIDTH_BYTE-1:DW+AW]
//   other: malformed.
//  mem_addr = addr[CLOG2(DATA_WIDTH_BYTE)+:MEM_ADDR_WIDTH]; low/upper bits ignored.
//  All outputs registered. Acceptance edge N (end of IDLE cycle): recv_flag=1 in N+1;
//   write: mem_en=1 (only if mask!=0), mem_we=mask, mem_wdata=data in N+1 -> WRITE
//   read : mem_en=1, mem_we=0 in N+1 -> RWAIT, counter=READ_LATENCY
//   malformed: err=1 in N+1, no mem_en -> DROP
//  States: IDLE; WRITE/DROP -> IDLE after 1 cycle (guarantees FIFO pop settles
//   before receivable is re-sampled); RWAIT decrements counter, at 0 captures
//   mem_rdata into send_data[DW-1:0] (upper bits 0), send_length=DATA_WIDTH_BYTE
//   -> RESP; RESP: when sendable, send_flag=1 next cycle -> IDLE, else hold.
//  READ_LATENCY=1: read send_flag first high in N+4 with sendable=1.
//  mem_en/mem_we/recv_flag/err/send_flag high for exactly one cycle per event.
//  No new packet popped while a response is pending (backpressure via RESP).
//  send_data/send_length hold last response until next capture.
//  Reset mid-read: pending response discarded; no send_flag after release.
// STRUCTURE
//  Shared header mem_packet.h (with common.h): SEND_BYTE, packet bit offsets,
//   read/write flag values, read/write lengths; memory_controller includes it too.
//  Sub-module mem_packet_decoder: combinational, recv_data/recv_length ->
//   is_read, is_write, addr, data, mask. FSM, counter, regs stay in top.
// TESTING
//  1 write len 9 {1,4'hF,32'h10,32'hDEADBEEF} -> N+1: recv_flag, mem_en, we=F,
//    addr=4, wdata=DEADBEEF; no send_flag.
//  2 read len 5 {0,32'h10}, RAM returns DEADBEEF, sendable=1 -> send_flag in N+4,
//    send_length=4, send_data=...0_DEADBEEF.
//  3 read with sendable=0 for 10 cycles, 2nd packet queued -> send_flag only after
//    sendable rises; 2nd packet not popped until then.
//  4 len 7 packet -> recv_flag + err pulse in N+1, no mem_en, IDLE in N+2.
//  5 write mask 4'b0101 -> mem_we=0101; mask 0 -> popped, mem_en stays 0.
//  6 READ_LATENCY=3 timing (send_flag N+6); RST_N low in RWAIT -> all outputs 0
//    at once, no response after release.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared packet layout for the memory link: flag values, lengths, bit offsets.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package memory_responder_pkg;

  // Opcode flag carried just above the address (read) or the mask (write).
  localparam logic READ_FLAG  = 1'b0;
  localparam logic WRITE_FLAG = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_DROP  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Largest packet on the link: data + address + mask bytes + flag byte.
  function automatic int send_byte(input int dwb, input int awb);
    return dwb + awb + dwb / 8 + 1;
  endfunction

  // A read carries only the address plus the flag byte.
  function automatic int read_len(input int awb);
    return awb + 1;
  endfunction

  // Bit position of the read flag: directly above the address.
  function automatic int read_flag_pos(input int awb);
    return 8 * awb;
  endfunction

  // Bit position of the write flag: above data, address and byte mask.
  function automatic int write_flag_pos(input int dwb, input int awb);
    return 8 * dwb + 8 * awb + dwb;
  endfunction

endpackage

// File: rtl/memory_responder_decoder.sv
// Splits a received packet into read/write classification and its fields.
// Latency: combinational.
// Backpressure: none; the caller decides when the fields are consumed.
// Ports: recv_data/recv_length in; is_read, is_write, addr, data, mask out.
module memory_responder_decoder
  import memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH_BYTE = 4,
  parameter int ADDR_WIDTH_BYTE = 4,
  localparam int DATA_WIDTH = 8 * DATA_WIDTH_BYTE,
  localparam int ADDR_WIDTH = 8 * ADDR_WIDTH_BYTE,
  localparam int SEND_BYTE  = send_byte(DATA_WIDTH_BYTE, ADDR_WIDTH_BYTE)
) (
  input  logic [SEND_BYTE*8-1:0]     recv_data,
  input  logic [4:0]                 recv_length,
  output logic                       is_read,
  output logic                       is_write,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [DATA_WIDTH-1:0]      data,
  output logic [DATA_WIDTH_BYTE-1:0] mask
);

  localparam int RD_FLAG = read_flag_pos(ADDR_WIDTH_BYTE);
  localparam int WR_FLAG = write_flag_pos(DATA_WIDTH_BYTE, ADDR_WIDTH_BYTE);
  localparam logic [4:0] RD_LEN = 5'(read_len(ADDR_WIDTH_BYTE));
  localparam logic [4:0] WR_LEN = 5'(SEND_BYTE);

  // Both length and flag must agree; anything else is malformed.
  assign is_read  = (recv_length == RD_LEN) && (recv_data[RD_FLAG] == READ_FLAG);
  assign is_write = (recv_length == WR_LEN) && (recv_data[WR_FLAG] == WRITE_FLAG);

  // Reads carry the address at the bottom; writes put data there instead.
  assign addr = is_write ? recv_data[DATA_WIDTH +: ADDR_WIDTH] : recv_data[ADDR_WIDTH-1:0];
  assign data = recv_data[DATA_WIDTH-1:0];
  assign mask = recv_data[WR_FLAG-1 -: DATA_WIDTH_BYTE];

  // Padding bits above the write flag carry no meaning.
  logic unused_recv_bits;
  assign unused_recv_bits = ^recv_data;

endmodule

// File: rtl/memory_responder.sv
// Memory-side link endpoint: pops requests, drives a word RAM, returns read data.
// Latency: outputs registered; write strobe 1 cycle after accept, read response
//   READ_LATENCY+3 cycles after accept. Backpressure: holds the response (and
//   pops nothing) until sendable; only one request is in flight at a time.
// Ports: CLK, RST_N; receivable/recv_data/recv_length/recv_flag (receive FIFO);
//   sendable/send_flag/send_data/send_length (send FIFO); mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata (RAM); err (malformed packet dropped).
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH_BYTE = 4,
  parameter int ADDR_WIDTH_BYTE = 4,
  parameter int MEM_ADDR_WIDTH  = 16,
  parameter int READ_LATENCY    = 1,
  localparam int DATA_WIDTH = 8 * DATA_WIDTH_BYTE,
  localparam int SEND_BYTE  = send_byte(DATA_WIDTH_BYTE, ADDR_WIDTH_BYTE)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       receivable,
  input  logic [SEND_BYTE*8-1:0]     recv_data,
  input  logic [4:0]                 recv_length,
  output logic                       recv_flag,
  input  logic                       sendable,
  output logic                       send_flag,
  output logic [SEND_BYTE*8-1:0]     send_data,
  output logic [4:0]                 send_length,
  output logic                       mem_en,
  output logic [DATA_WIDTH_BYTE-1:0] mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       err
);

  localparam int ADDR_WIDTH = 8 * ADDR_WIDTH_BYTE;
  localparam int SEND_W     = SEND_BYTE * 8;
  localparam int ADDR_LSB   = $clog2(DATA_WIDTH_BYTE);
  localparam int CNT_W      = $clog2(READ_LATENCY + 1);

  state_t                     state;
  logic [CNT_W-1:0]           lat_cnt;
  logic                       dec_is_read;
  logic                       dec_is_write;
  logic [ADDR_WIDTH-1:0]      dec_addr;
  logic [DATA_WIDTH-1:0]      dec_data;
  logic [DATA_WIDTH_BYTE-1:0] dec_mask;
  logic [MEM_ADDR_WIDTH-1:0]  word_addr;

  memory_responder_decoder #(
    .DATA_WIDTH_BYTE(DATA_WIDTH_BYTE),
    .ADDR_WIDTH_BYTE(ADDR_WIDTH_BYTE)
  ) u_decoder (
    .recv_data  (recv_data),
    .recv_length(recv_length),
    .is_read    (dec_is_read),
    .is_write   (dec_is_write),
    .addr       (dec_addr),
    .data       (dec_data),
    .mask       (dec_mask)
  );

  // Byte address to word address; byte-offset and high bits are don't-care.
  assign word_addr = dec_addr[ADDR_LSB +: MEM_ADDR_WIDTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^dec_addr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      recv_flag   <= 1'b0;
      send_flag   <= 1'b0;
      send_data   <= '0;
      send_length <= '0;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err         <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      recv_flag <= 1'b0;
      send_flag <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      err       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (receivable) begin
            recv_flag <= 1'b1;
            if (dec_is_write) begin
              // An all-zero mask still pops the packet but touches no RAM.
              mem_en    <= |dec_mask;
              mem_we    <= dec_mask;
              mem_addr  <= word_addr;
              mem_wdata <= dec_data;
              state     <= ST_WRITE;
            end else if (dec_is_read) begin
              mem_en   <= 1'b1;
              mem_addr <= word_addr;
              lat_cnt  <= CNT_W'(READ_LATENCY);
              state    <= ST_RWAIT;
            end else begin
              err   <= 1'b1;
              state <= ST_DROP;
            end
          end
        end

        // One idle beat so the FIFO pop lands before receivable is looked at again.
        ST_WRITE, ST_DROP: state <= ST_IDLE;

        ST_RWAIT: begin
          if (lat_cnt == '0) begin
            send_data   <= SEND_W'(mem_rdata);
            send_length <= 5'(DATA_WIDTH_BYTE);
            state       <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (sendable) begin
            send_flag <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench: two responders (read latency 1 and 3), each with its own RAM,
// driven by directed and random requests checked against a word-level memory model.
module tb_memory_responder;

  localparam int PW = 72;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  logic        receivable  [2];
  logic [PW-1:0] recv_data [2];
  logic [4:0]  recv_length [2];
  logic        recv_flag   [2];
  logic        sendable    [2];
  logic        send_flag   [2];
  logic [PW-1:0] send_data [2];
  logic [4:0]  send_length [2];
  logic        mem_en      [2];
  logic [3:0]  mem_we      [2];
  logic [15:0] mem_addr    [2];
  logic [31:0] mem_wdata   [2];
  logic [31:0] mem_rdata   [2];
  logic        err         [2];

  memory_responder #(.READ_LATENCY(1)) dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .receivable(receivable[0]), .recv_data(recv_data[0]), .recv_length(recv_length[0]),
    .recv_flag(recv_flag[0]), .sendable(sendable[0]), .send_flag(send_flag[0]),
    .send_data(send_data[0]), .send_length(send_length[0]), .mem_en(mem_en[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .err(err[0])
  );

  memory_responder #(.READ_LATENCY(3)) dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .receivable(receivable[1]), .recv_data(recv_data[1]), .recv_length(recv_length[1]),
    .recv_flag(recv_flag[1]), .sendable(sendable[1]), .send_flag(send_flag[1]),
    .send_data(send_data[1]), .send_length(send_length[1]), .mem_en(mem_en[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .err(err[1])
  );

  function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [3:0] we,
                                            input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // Synchronous RAMs with LAT cycles from strobe to valid data.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] store [0:65535];
    logic [31:0] pipe [LAT];
    initial for (int i = 0; i < 65536; i++) store[i] = {16'hC0DE, 16'(i)};
    assign mem_rdata[g] = pipe[LAT-1];
    always @(posedge CLK) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      if (mem_en[g] && mem_we[g] == 4'h0) pipe[0] <= store[mem_addr[g]];
      if (mem_en[g] && mem_we[g] != 4'h0)
        store[mem_addr[g]] <= ram_merge(store[mem_addr[g]], mem_we[g], mem_wdata[g]);
    end
  end

  // Reference model: word contents per (dut, word index), default pattern when unwritten.
  logic [31:0] model_mem [int];
  int n_pass = 0;
  int n_total = 0;
  bit pend = 1'b0;
  logic [PW-1:0] pend_pkt;
  int pend_len = 0;

  function automatic logic [31:0] model_rd(input int key);
    if (model_mem.exists(key)) return model_mem[key];
    return {16'hC0DE, 16'(key % 65536)};
  endfunction

  function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old & ~bm) | (d & bm);
  endfunction

  function automatic logic [PW-1:0] mk_wr(input logic [3:0] m, input logic [31:0] a,
                                          input logic [31:0] d);
    return {3'b000, 1'b1, m, a, d};
  endfunction

  function automatic logic [PW-1:0] mk_rd(input logic [31:0] a);
    return {39'b0, 1'b0, a};
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input int d, input string tag);
    check(tag, {recv_flag[d], send_flag[d], mem_en[d], err[d], mem_we[d], send_length[d],
                mem_addr[d], mem_wdata[d], send_data[d]}, '0);
  endtask

  // One request from presentation to completion; returns with the DUT idle.
  task automatic txn(input int d, input logic [PW-1:0] pkt, input int len, input int stall);
    int lat, kind, cyc, exp_cyc, key;
    logic [31:0] a, exp_rd;
    logic [3:0] m;
    bit leak;
    lat = (d == 0) ? 1 : 3;
    a = (len == 9) ? pkt[63:32] : pkt[31:0];
    m = pkt[67:64];
    if (len == 5 && pkt[32] == 1'b0) kind = 1;
    else if (len == 9 && pkt[68] == 1'b1) kind = 2;
    else kind = 0;
    key = d * 65536 + int'(a / 4) % 65536;
    receivable[d] = 1'b1;
    recv_data[d] = pkt;
    recv_length[d] = 5'(len);
    sendable[d] = (stall == 0);
    @(negedge CLK);
    check("accept_pop", {recv_flag[d], send_flag[d]}, 2'b10);
    if (pend) begin
      recv_data[d] = pend_pkt;
      recv_length[d] = 5'(pend_len);
    end else begin
      receivable[d] = 1'b0;
    end
    case (kind)
      0: check("bad_err", {err[d], mem_en[d]}, 2'b10);
      2: begin
        check("wr_en_err", {mem_en[d], err[d]}, {m != 4'h0, 1'b0});
        if (m != 4'h0)
          check("wr_bus", {mem_we[d], mem_addr[d], mem_wdata[d]}, {m, 16'(a / 4), pkt[31:0]});
        model_mem[key] = apply_mask(model_rd(key), pkt[31:0], m);
      end
      default: begin
        check("rd_strobe", {mem_en[d], mem_we[d], mem_addr[d], err[d]},
              {1'b1, 4'h0, 16'(a / 4), 1'b0});
        exp_rd = model_rd(key);
        exp_cyc = ((lat + 2 > stall + 1) ? lat + 2 : stall + 1) + 1;
        cyc = 1;
        leak = 1'b0;
        while (!send_flag[d] && cyc < 60) begin
          if (cyc > 1 && (recv_flag[d] || mem_en[d])) leak = 1'b1;
          @(negedge CLK);
          cyc++;
          if (cyc == 1 + stall) sendable[d] = 1'b1;
        end
        check("rd_no_pop_or_access", leak, 1'b0);
        check("rd_resp_cycle", cyc, exp_cyc);
        check("rd_resp", {send_length[d], send_data[d]}, {5'd4, 40'h0, exp_rd});
      end
    endcase
    @(negedge CLK);
    if (kind == 1) check("rd_flag_pulse", send_flag[d], 1'b0);
    else check("pulse_clear", {recv_flag[d], mem_en[d], err[d], send_flag[d]}, 4'h0);
  endtask

  initial begin
    logic [PW-1:0] pkt;
    logic [31:0] a, wd;
    logic [3:0] m;
    int d, len, r, stall;
    bit leak;
    for (int i = 0; i < 2; i++) begin
      receivable[i] = 1'b0;
      recv_data[i] = '0;
      recv_length[i] = '0;
      sendable[i] = 1'b0;
    end
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk_zero(0, "reset_a");
    chk_zero(1, "reset_b");
    RST_N = 1'b1;
    @(negedge CLK);

    // Full-mask write, then read it back.
    txn(0, mk_wr(4'hF, 32'h10, 32'hDEADBEEF), 9, 0);
    check("t1_held_addr_data", {mem_addr[0], mem_wdata[0]}, {16'h0004, 32'hDEADBEEF});
    txn(0, mk_rd(32'h10), 5, 0);
    check("t2_data", {send_length[0], send_data[0]}, {5'd4, 72'hDEADBEEF});

    // Response stalled by sendable; a queued write must wait behind it.
    pend = 1'b1;
    pend_pkt = mk_wr(4'h3, 32'h20, 32'h12345678);
    pend_len = 9;
    txn(0, mk_rd(32'h10), 5, 10);
    pend = 1'b0;
    check("t3_second_pop", {recv_flag[0], mem_en[0], mem_we[0], mem_addr[0]},
          {1'b1, 1'b1, 4'h3, 16'h0008});
    receivable[0] = 1'b0;
    model_mem[8] = apply_mask(model_rd(8), 32'h12345678, 4'h3);
    @(negedge CLK);
    txn(0, mk_rd(32'h20), 5, 0);
    check("t3_readback", send_data[0], {40'h0, 32'hC0DE5678});

    // Malformed packets: wrong length, wrong flags.
    txn(0, mk_wr(4'hF, 32'h30, 32'h1), 7, 0);
    pkt = mk_rd(32'h30); pkt[32] = 1'b1;
    txn(0, pkt, 5, 0);
    pkt = mk_wr(4'hF, 32'h30, 32'h1); pkt[68] = 1'b0;
    txn(0, pkt, 9, 0);

    // Partial and empty masks.
    txn(0, mk_wr(4'b0101, 32'h10, 32'hA1B2C3D4), 9, 0);
    txn(0, mk_rd(32'h10), 5, 0);
    check("t5_partial", send_data[0], {40'h0, 32'hDEB2BED4});
    txn(0, mk_wr(4'h0, 32'h10, 32'h0), 9, 0);
    txn(0, mk_rd(32'h10), 5, 0);

    // Latency-3 responder timing.
    txn(1, mk_wr(4'hF, 32'h40, 32'hCAFEF00D), 9, 0);
    txn(1, mk_rd(32'h40), 5, 0);
    check("t6_data", send_data[1], {40'h0, 32'hCAFEF00D});

    // Reset while a read is outstanding: everything clears, no late response.
    sendable[1] = 1'b1;
    receivable[1] = 1'b1;
    recv_data[1] = mk_rd(32'h40);
    recv_length[1] = 5'd5;
    @(negedge CLK);
    check("t6_rd_accept", {recv_flag[1], mem_en[1]}, 2'b11);
    receivable[1] = 1'b0;
    RST_N = 1'b0;
    #1;
    chk_zero(1, "t6_async_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    leak = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (send_flag[1] || recv_flag[1] || mem_en[1]) leak = 1'b1;
    end
    check("t6_no_resp_after_reset", leak, 1'b0);

    // Random mix across both responders.
    for (int it = 0; it < 60; it++) begin
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      wd = $urandom;
      m = 4'($urandom_range(0, 15));
      stall = 0;
      if (r < 4) begin
        pkt = mk_wr(m, a, wd); len = 9;
      end else if (r < 8) begin
        pkt = mk_rd(a); len = 5; stall = $urandom_range(0, 6);
      end else if (r == 8) begin
        pkt = mk_wr(m, a, wd); len = $urandom_range(0, 31);
        if (len == 5 || len == 9) len = 7;
      end else if ($urandom_range(0, 1) == 1) begin
        pkt = mk_wr(m, a, wd); pkt[68] = 1'b0; len = 9;
      end else begin
        pkt = mk_rd(a); pkt[32] = 1'b1; len = 5;
      end
      txn(d, pkt, len, stall);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
